vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 raster counter/sync logic.
- Generates hsync/vsync with configurable timing and polarity, plus registered pixel coordinates, an active-video flag, line/frame strobes and a frame-locked animation tick.
- Runs off a system clock with a pixel enable. Drawing logic downstream consumes x/y/active instead of raw counters.
- Replaces level-sampled animation clocks with a clean one-cycle tick.

Parameters:
- CW, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640, active pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, active lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 29, vertical back porch (lines).
- HS_POL, 0, hsync asserted level.
- VS_POL, 0, vsync asserted level.
- PIPE, 2, output latency in pixel-enable cycles, range 1..4.
- ANIM_DIV, 1, frames per anim_tick, at least 1.

Ports:
- dclk  in  1  system clock.
- clr  in  1  reset; asynchronous, active-high.
- pix_en  in  1  pixel enable; counters and pipeline advance only when 1.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- active  out  1  inside active video.
- x  out  CW  pixel column, 0..H_ACTIVE-1.
- y  out  CW  pixel row, 0..V_ACTIVE-1.
- line_start  out  1  one-enable pulse at hc==0.
- frame_start  out  1  one-enable pulse at hc==0 && vc==0.
- anim_tick  out  1  one-enable pulse every ANIM_DIV frames.
- frame_cnt  out  16  frames completed since reset, wraps.

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800); V_TOTAL likewise (521).
- Line order: sync, back porch, active, front porch. Sync starts at counter 0.
- On pix_en:
  - hc increments; at H_TOTAL-1 it wraps to 0 and vc increments.
  - vc wraps to 0 at V_TOTAL-1 together with the hc wrap.
- pix_en=0: all state and outputs hold. Pulses stay asserted across held cycles but count as one pixel.
- Stage-0 combinational decode from hc/vc:
  - hs_a = hc<H_SYNC; vs_a = vc<V_SYNC.
  - act = hc in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vc in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - x = act ? hc-(H_SYNC+H_BP) : 0; y = act ? vc-(V_SYNC+V_BP) : 0. Both are zero outside active video.
- Outputs pass through a PIPE-deep register shift chain clocked by pix_en. All outputs stay mutually aligned.
- hsync = hs_a ? HS_POL : !HS_POL; vsync likewise with VS_POL.
- anim_cnt (frame counter for the tick), evaluated at stage-0 frame_start:
  - if anim_cnt==ANIM_DIV-1: tick=1, anim_cnt=0; else anim_cnt++.
  - The first frame after reset is frame 1. ANIM_DIV=1 ticks every frame including the first; ANIM_DIV=4 ticks at frames 4, 8, ...
- frame_cnt increments when hc==H_TOTAL-1 && vc==V_TOTAL-1, on pix_en. It is registered directly with no pipeline delay and is stable across active video.
- Reset values (async; clears state immediately, including mid-frame):
  - hc=vc=0; anim_cnt=0; frame_cnt=0; all pipe stages cleared.
  - hsync=!HS_POL, vsync=!VS_POL; active=0; x=y=0; line_start=frame_start=anim_tick=0.
- First pix_en after clr release processes hc=vc=0. frame_start/line_start appear PIPE enables later.
- Arithmetic is unsigned CW-bit; no overflow is possible given the CW constraint. The bench asserts the constraint at elaboration.

Decomposition:
- Package vga_pkg holds:
  - default 640x480@60 timing constants;
  - derived H_TOTAL/V_TOTAL/H_ACT_START/V_ACT_START functions;
  - the 8-bit RRRGGGBB colour constants (black, white, yellow, cyan, green, magenta, red, blue) shared by drawing blocks.
- One sub-module, vga_delay_line: a width- and depth-parametrised shift register with enable and async clear. It is instantiated for the {hs, vs, act, x, y, pulses} bundle.

Test Plan:
- Defaults, pix_en=1, release clr at t0 -> hsync low on cycles t0+2..t0+97, high for the next 704; period 800 cycles.
- Defaults -> first active=1 at cycle t0+146 with x=0, y=0; x=639 at t0+785; active=0 at t0+786; 640 active pixels per line, 480 active lines per frame.
- Defaults -> vsync low for exactly 1600 cycles; frame_start period 416800 cycles; frame_cnt = 1 after the first 416800 cycles.
- pix_en toggling 1010... -> all periods double; outputs hold on pix_en=0; active count per line is still 640 enables.
- ANIM_DIV=3, HS_POL=VS_POL=1, small timing (H: 4/2/1/1, V: 3/1/1/1) -> sync pulses high-true; anim_tick coincides with frame_start of frames 3 and 6 only.
- Assert clr mid-active-line (x=300) -> all outputs take reset values immediately; after release, counting restarts at hc=vc=0 with identical timing to the first test.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing defaults, derived-timing helpers
// and 8-bit RRRGGGBB colours for drawing blocks.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 29;

  function automatic int h_total(int sync, int bp, int act, int fp);
    return sync + bp + act + fp;
  endfunction

  function automatic int v_total(int sync, int bp, int act, int fp);
    return sync + bp + act + fp;
  endfunction

  function automatic int h_act_start(int sync, int bp);
    return sync + bp;
  endfunction

  function automatic int v_act_start(int sync, int bp);
    return sync + bp;
  endfunction

  localparam logic [7:0] COL_BLACK   = 8'h00;
  localparam logic [7:0] COL_WHITE   = 8'hFF;
  localparam logic [7:0] COL_YELLOW  = 8'hFC;
  localparam logic [7:0] COL_CYAN    = 8'h1F;
  localparam logic [7:0] COL_GREEN   = 8'h1C;
  localparam logic [7:0] COL_MAGENTA = 8'hE3;
  localparam logic [7:0] COL_RED     = 8'hE0;
  localparam logic [7:0] COL_BLUE    = 8'h03;

  typedef struct packed {
    logic line_start;
    logic frame_start;
    logic anim_tick;
  } pulse_t;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enabled shift register of configurable width and
// depth with asynchronous clear to zero.
module vga_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster counters, sync/active decode,
// aligned output pipeline, frame counter and frame-locked anim tick.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CW       = 10,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE     = 2,
  parameter int ANIM_DIV = 1
) (
  input  logic          dclk,
  input  logic          clr,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          anim_tick,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOT = h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOT = v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int H_ST  = h_act_start(H_SYNC, H_BP);
  localparam int V_ST  = v_act_start(V_SYNC, V_BP);
  localparam int AW    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int BW    = 3 + 2 * CW + 3;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOT - 1);
  localparam logic [CW-1:0] HS_END = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_END = CW'(V_SYNC);
  localparam logic [CW-1:0] HA_BEG = CW'(H_ST);
  localparam logic [CW-1:0] HA_END = CW'(H_ST + H_ACTIVE);
  localparam logic [CW-1:0] VA_BEG = CW'(V_ST);
  localparam logic [CW-1:0] VA_END = CW'(V_ST + V_ACTIVE);
  localparam logic [AW-1:0] A_LAST = AW'(ANIM_DIV - 1);

  logic [CW-1:0] hc, vc;
  logic [AW-1:0] anim_cnt;
  logic          h_last, v_last, anim_wrap;
  logic          hs_a, vs_a, act;
  logic [CW-1:0] x0, y0;
  pulse_t        p0, pq;
  logic          hs_q, vs_q;
  logic [BW-1:0] bundle_d, bundle_q;

  assign h_last    = hc == H_LAST;
  assign v_last    = vc == V_LAST;
  assign anim_wrap = anim_cnt == A_LAST;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hc <= '0;
        vc <= v_last ? '0 : vc + CW'(1);
      end else begin
        hc <= hc + CW'(1);
      end
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      frame_cnt <= '0;
      anim_cnt  <= '0;
    end else if (pix_en) begin
      if (h_last && v_last) frame_cnt <= frame_cnt + 16'd1;
      if (p0.frame_start) anim_cnt <= anim_wrap ? '0 : anim_cnt + AW'(1);
    end
  end

  always_comb begin
    hs_a = hc < HS_END;
    vs_a = vc < VS_END;
    act  = (hc >= HA_BEG) && (hc < HA_END)
        && (vc >= VA_BEG) && (vc < VA_END);
    x0   = act ? hc - HA_BEG : '0;
    y0   = act ? vc - VA_BEG : '0;
    p0.line_start  = hc == '0;
    p0.frame_start = (hc == '0) && (vc == '0);
    p0.anim_tick   = (hc == '0) && (vc == '0) && anim_wrap;
  end

  // Sync is carried as an asserted flag so a cleared stage reads idle.
  assign bundle_d = {hs_a, vs_a, act, x0, y0, p0};

  vga_delay_line #(
    .W     (BW),
    .DEPTH (PIPE)
  ) u_dly (
    .clk (dclk),
    .clr (clr),
    .en  (pix_en),
    .d   (bundle_d),
    .q   (bundle_q)
  );

  assign {hs_q, vs_q, active, x, y, pq} = bundle_q;

  assign hsync       = hs_q ? HS_POL : !HS_POL;
  assign vsync       = vs_q ? VS_POL : !VS_POL;
  assign line_start  = pq.line_start;
  assign frame_start = pq.frame_start;
  assign anim_tick   = pq.anim_tick;

endmodule
